grid_row_scanner: RTL and testbench
===================================

# grid_row_scanner

Downstream consumer of the 24x24 Game-of-Life datapath's evolved-grid output. On each load request it snapshots the 576-bit grid and streams it out one 24-bit row per transfer over a valid/ready handshake, with row index, start and last markers. It sits between the datapath and the display/host sink. The snapshot isolates the sink from generation updates that occur mid-scan.

## Interface
Parameters:
- ROWS, 24, number of grid rows
- COLS, 24, cells per row; grid width is ROWS*COLS

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- grid  input  ROWS*COLS  evolved grid; row r = grid[r*COLS +: COLS], row 0 = bits 23:0
- load  input  1  one-cycle request to snapshot grid and start a frame
- out_ready  input  1  sink accepts row this cycle
- row_valid  output  1  row_data/row_idx valid
- row_data  output  COLS  current row bits
- row_idx  output  5  current row number, 0..ROWS-1
- row_first  output  1  high with row 0
- row_last  output  1  high with row ROWS-1
- busy  output  1  frame in progress (state SCAN)
- frame_done  output  1  one-cycle pulse after last row transfers
- overrun  output  1  sticky: load arrived while busy and was dropped
- row_pop  output  5  live cells in row_data (0..24); ROW_POPCOUNT_EN only
- frame_pop  output  10  live cells in last completed frame (0..576); ROW_POPCOUNT_EN only

## Operation
- States: IDLE, SCAN.
- IDLE: busy=0, row_valid=0. load=1 -> snapshot<=grid, row_idx<=0, row_data<=row 0, row_valid<=1, -> SCAN.
- SCAN: transfer = row_valid & out_ready. On transfer with row_idx<ROWS-1: row_idx+1, row_data<=snapshot row row_idx+1.
- On transfer of row ROWS-1 with load=0: row_valid<=0, frame_done<=1 next cycle, -> IDLE.
- On transfer of row ROWS-1 with load=1: back-to-back frame; new snapshot, row_idx<=0, stay SCAN, frame_done still pulses; overrun not set.
- load in SCAN other than on final transfer: dropped, snapshot unchanged, overrun<=1 (cleared only by reset).
- row_valid=1 with out_ready=0: row_data, row_idx, row_first, row_last, row_pop held stable.
- row_first = row_valid & (row_idx==0); row_last = row_valid & (row_idx==ROWS-1).
- grid changes after load do not affect the frame in flight.

## Timing
- load sampled at edge N -> row_valid=1 with row 0 from edge N+1.
- Full-throughput frame (out_ready held 1): ROWS cycles of row_valid, frame_done one cycle after the row-23 transfer edge; next load accepted in IDLE the same cycle frame_done is high.
- All outputs registered; no combinational path from out_ready or load to any output.
- Reset values: row_valid 0, row_data 0, row_idx 0, row_first 0, row_last 0, busy 0, frame_done 0, overrun 0, row_pop 0, frame_pop 0; state IDLE.
- Reset mid-scan: frame aborted, no frame_done, outputs to reset values next edge; reset dominates load.

## Configuration
- Macro ROW_POPCOUNT_EN.
- Defined: row_pop = popcount(row_data), registered alongside row_data. A frame accumulator sums row_pop on each transfer and clears on accepted load. frame_pop updates on the same edge frame_done rises and holds until the next frame completes.
- Undefined: no popcount or accumulator logic; row_pop and frame_pop tied to 0.

## Test plan
- Reset 4 cycles, load with grid=0, out_ready=1 -> 24 rows, all row_data=0, row_idx 0..23, row_first on idx 0, row_last on idx 23, frame_done one cycle after last; popcount build: frame_pop=0.
- grid row0=24'hFFFFFF, row23=24'h000001, others 0; out_ready=1 -> row 0 data FFFFFF (row_pop 24), row 23 data 000001 (row_pop 1); frame_pop=25.
- out_ready low for 5 cycles during row 7 -> row_idx=7 and row_data held 5 cycles; completion delayed by exactly 5 cycles.
- load at row 10 with a different grid -> overrun=1 stays set, remaining rows from original snapshot; change grid input mid-scan -> output unaffected.
- load coincident with row-23 transfer -> frame_done pulses, next cycle row_valid=1, row_idx=0 with new grid row 0, overrun=0.
- reset asserted at row 12 -> next edge all outputs 0, no frame_done; subsequent load restarts at row 0.

Source files
------------

// File: rtl/grid_row_scanner.sv
// Snapshots the evolved Game-of-Life grid on load and streams it out one row per valid/ready transfer.
// Optional per-row / per-frame live-cell counts are built when ROW_POPCOUNT_EN is defined.
module grid_row_scanner #(
    parameter int unsigned ROWS = 24,
    parameter int unsigned COLS = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] grid,
    input  logic                 load,
    input  logic                 out_ready,
    output logic                 row_valid,
    output logic [COLS-1:0]      row_data,
    output logic [4:0]           row_idx,
    output logic                 row_first,
    output logic                 row_last,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic [4:0]           row_pop,
    output logic [9:0]           frame_pop
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t            r_state;
    logic [COLS-1:0]   r_snap [ROWS];
    logic              r_row_valid;
    logic [COLS-1:0]   r_row_data;
    logic [4:0]        r_row_idx;
    logic              r_row_first;
    logic              r_row_last;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_overrun;

    logic [COLS-1:0]   w_grid_rows [ROWS];
    logic [4:0]        w_next_idx;
    logic              w_at_last;
    logic              w_xfer;
    logic              w_advance;
    logic              w_final;
    logic              w_accept;

    // Unpack the flat grid into rows; row 0 occupies the low bits.
    for (genvar g = 0; g < ROWS; g++) begin : g_rows
        assign w_grid_rows[g] = grid[g*COLS +: COLS];
    end

    assign w_next_idx = r_row_idx + 5'd1;
    assign w_at_last  = (r_row_idx == 5'(ROWS - 1));
    assign w_xfer     = r_row_valid & out_ready;
    assign w_advance  = w_xfer & ~w_at_last;
    assign w_final    = w_xfer & w_at_last;
    // A load is honoured in IDLE or exactly on the final row transfer (back-to-back frame).
    assign w_accept   = load & ((r_state == ST_IDLE) | w_final);

    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_snap <= w_grid_rows;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_row_valid  <= 1'b0;
            r_row_data   <= '0;
            r_row_idx    <= 5'd0;
            r_row_first  <= 1'b0;
            r_row_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= w_final;
            if (load && (r_state == ST_SCAN) && !w_final) begin
                r_overrun <= 1'b1;
            end

            if (w_accept) begin
                r_state     <= ST_SCAN;
                r_busy      <= 1'b1;
                r_row_valid <= 1'b1;
                r_row_idx   <= 5'd0;
                r_row_data  <= w_grid_rows[0];
                r_row_first <= 1'b1;
                r_row_last  <= (ROWS == 1);
            end else if (w_advance) begin
                r_row_idx   <= w_next_idx;
                r_row_data  <= r_snap[w_next_idx];
                r_row_first <= 1'b0;
                r_row_last  <= (w_next_idx == 5'(ROWS - 1));
            end else if (w_final) begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_row_valid <= 1'b0;
                r_row_first <= 1'b0;
                r_row_last  <= 1'b0;
            end
        end
    end

    assign row_valid  = r_row_valid;
    assign row_data   = r_row_data;
    assign row_idx    = r_row_idx;
    assign row_first  = r_row_first;
    assign row_last   = r_row_last;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

`ifdef ROW_POPCOUNT_EN
    logic [4:0] r_row_pop;
    logic [9:0] r_frame_acc;
    logic [9:0] r_frame_pop;

    function automatic logic [4:0] f_popcount(input logic [COLS-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < COLS; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    // row_pop tracks row_data; the accumulator sums every transferred row of the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_pop   <= 5'd0;
            r_frame_acc <= 10'd0;
            r_frame_pop <= 10'd0;
        end else begin
            if (w_accept) begin
                r_row_pop <= f_popcount(w_grid_rows[0]);
            end else if (w_advance) begin
                r_row_pop <= f_popcount(r_snap[w_next_idx]);
            end

            if (w_accept) begin
                r_frame_acc <= 10'd0;
            end else if (w_xfer) begin
                r_frame_acc <= r_frame_acc + 10'(r_row_pop);
            end

            if (w_final) begin
                r_frame_pop <= r_frame_acc + 10'(r_row_pop);
            end
        end
    end

    assign row_pop   = r_row_pop;
    assign frame_pop = r_frame_pop;
`else
    assign row_pop   = 5'd0;
    assign frame_pop = 10'd0;
`endif

endmodule

// File: tb/tb_grid_row_scanner.sv
// Directed + random bench for grid_row_scanner, checked every cycle against a frame-level reference model.
module tb_grid_row_scanner;

    localparam int unsigned ROWS = 24;
    localparam int unsigned COLS = 24;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [ROWS*COLS-1:0] grid;
    logic                 load;
    logic                 out_ready;
    logic                 row_valid;
    logic [COLS-1:0]      row_data;
    logic [4:0]           row_idx;
    logic                 row_first;
    logic                 row_last;
    logic                 busy;
    logic                 frame_done;
    logic                 overrun;
    logic [4:0]           row_pop;
    logic [9:0]           frame_pop;

    always #5 clk = ~clk;

    grid_row_scanner #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk        (clk),
        .reset      (reset),
        .grid       (grid),
        .load       (load),
        .out_ready  (out_ready),
        .row_valid  (row_valid),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_first  (row_first),
        .row_last   (row_last),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .row_pop    (row_pop),
        .frame_pop  (frame_pop)
    );

`ifdef ROW_POPCOUNT_EN
    localparam bit POP_EN = 1'b1;
`else
    localparam bit POP_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the frame in flight, how many rows have been delivered, sticky flags.
    logic [COLS-1:0] m_snap [ROWS];
    bit              m_active;
    int              m_k;
    bit              m_done;
    bit              m_ovr;
    int              m_acc;
    int              m_fpop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_start();
        logic [ROWS*COLS-1:0] t;
        t = grid;
        for (int r = 0; r < int'(ROWS); r++) begin
            m_snap[r] = t[COLS-1:0];
            t = t >> COLS;
        end
        m_k      = 0;
        m_acc    = 0;
        m_active = 1'b1;
    endtask

    task automatic model_step(input bit rst, input bit ld, input bit rdy);
        if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_done   = 1'b0;
            m_ovr    = 1'b0;
            m_acc    = 0;
            m_fpop   = 0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (ld) model_start();
            end else begin
                if (ld && !(rdy && m_k == int'(ROWS) - 1)) m_ovr = 1'b1;
                if (rdy) begin
                    m_acc += $countones(m_snap[m_k]);
                    if (m_k < int'(ROWS) - 1) begin
                        m_k++;
                    end else begin
                        m_done = 1'b1;
                        m_fpop = m_acc;
                        if (ld) model_start();
                        else    m_active = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("row_valid",  32'(row_valid),  32'(m_active));
        chk("busy",       32'(busy),       32'(m_active));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        chk("row_first",  32'(row_first),  32'(m_active && m_k == 0));
        chk("row_last",   32'(row_last),   32'(m_active && m_k == int'(ROWS) - 1));
        chk("frame_pop",  32'(frame_pop),  POP_EN ? 32'(m_fpop) : 32'd0);
        if (m_active) begin
            chk("row_idx",  32'(row_idx),  32'(m_k));
            chk("row_data", 32'(row_data), 32'(m_snap[m_k]));
            chk("row_pop",  32'(row_pop),  POP_EN ? 32'($countones(m_snap[m_k])) : 32'd0);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare just after the edge.
    task automatic cyc(input bit rst, input bit ld, input bit rdy);
        reset     = rst;
        load      = ld;
        out_ready = rdy;
        @(posedge clk);
        model_step(rst, ld, rdy);
        #1;
        check_outputs();
    endtask

    task automatic rand_grid();
        logic [ROWS*COLS-1:0] g;
        g = '0;
        for (int i = 0; i < 18; i++) begin
            g = {g[ROWS*COLS-33:0], 32'($urandom)};
        end
        grid = g;
    endtask

    task automatic check_reset_zero();
        chk("rst_row_data", 32'(row_data), 32'd0);
        chk("rst_row_idx",  32'(row_idx),  32'd0);
        chk("rst_row_pop",  32'(row_pop),  32'd0);
    endtask

    initial begin
        grid      = '0;
        reset     = 1'b1;
        load      = 1'b0;
        out_ready = 1'b0;

        // Reset, then an all-zero frame at full throughput
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        check_reset_zero();
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b0, 1'b1);

        // Full first row, single bit in the last row
        grid = '0;
        grid[23:0]    = 24'hFFFFFF;
        grid[575:552] = 24'h000001;
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("frame_pop_25", 32'(frame_pop), POP_EN ? 32'd25 : 32'd0);

        // Sink stalls for five cycles on row 7
        rand_grid();
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) cyc(1'b0, 1'b0, 1'b1);

        // Load dropped at row 10; grid churns while the frame is in flight
        rand_grid();
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1);
        rand_grid();
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            rand_grid();
            cyc(1'b0, 1'b0, 1'b1);
        end

        // Clear overrun, then back-to-back frames via load on the final transfer
        cyc(1'b1, 1'b0, 1'b0);
        rand_grid();
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 23; i++) cyc(1'b0, 1'b0, 1'b1);
        rand_grid();
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b0, 1'b1);

        // Reset mid-frame at row 12, then restart
        rand_grid();
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        check_reset_zero();
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b0, 1'b1);

        // Random traffic: sporadic loads, bursty ready, occasional reset
        for (int i = 0; i < 400; i++) begin
            rand_grid();
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) < 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
